// File: rtl/periph_to_csb_pipelined.sv
// Generic synchronous FIFO: registered pointers, combinational head read.
// Latency: a pushed entry is visible at pop_dat the cycle after the push.
// Backpressure: push is ignored while full, pop is ignored while empty.
module fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_dat,
    output logic             full,
    output logic             empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt;
    logic             do_push;
    logic             do_pop;

    assign full    = (cnt == CW'(DEPTH));
    assign empty   = (cnt == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign pop_dat = mem[rd_ptr];

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end
endmodule

// Bridge HWPE periph slave port to NVDLA CSB master, in-order, several requests in flight.
// Latency: read granted T0 -> csb_valid T1 -> csb_r_valid T2 -> periph_r_valid T3.
// Backpressure: gnt drops while the request FIFO is full; csb_valid held until csb_ready.
module periph_to_csb_pipelined #(
    parameter int          ID_WIDTH  = 8,
    parameter int          REQ_DEPTH = 4,
    parameter int          MAX_OUTST = 4,
    parameter bit          CHECK_ID  = 1'b1,
    parameter logic [15:0] CSB_ID    = 16'h0000,
    parameter logic [31:0] ERR_DATA  = 32'hBADC0DE5
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                periph_req,
    input  logic [31:0]         periph_add,
    input  logic                periph_wen,
    input  logic [3:0]          periph_be,
    input  logic [31:0]         periph_data,
    input  logic [ID_WIDTH-1:0] periph_id,
    output logic                periph_gnt,
    output logic                periph_r_valid,
    output logic [31:0]         periph_r_data,
    output logic [ID_WIDTH-1:0] periph_r_id,
    output logic                periph_r_err,
    output logic                csb_valid,
    input  logic                csb_ready,
    output logic [15:0]         csb_addr,
    output logic [31:0]         csb_wdat,
    output logic                csb_write,
    output logic                csb_nposted,
    input  logic                csb_r_valid,
    input  logic [31:0]         csb_r_data,
    input  logic                csb_wr_complete,
    output logic                unexp_resp
);
    typedef struct packed {
        logic [15:0]         addr;
        logic [31:0]         data;
        logic                write;
        logic [ID_WIDTH-1:0] id;
        logic                err;
    } req_t;

    typedef struct packed {
        logic [ID_WIDTH-1:0] id;
        logic                write;
        logic                err;
    } trk_t;

    typedef enum logic [1:0] {IDLE, ISSUE, ERRWAIT} state_t;

    state_t state;
    req_t   new_req;
    req_t   reqf_head;
    req_t   head;
    logic   head_vld;
    logic   reqf_full;
    logic   reqf_empty;
    logic   reqf_pop;
    trk_t   trk_push_dat;
    trk_t   trk_head;
    logic   trk_push;
    logic   trk_pop;
    logic   trk_full;
    logic   trk_empty;
    logic   hd_ok;
    logic   rd_hit;
    logic   wr_hit;
    logic   err_done;

    assign periph_gnt  = rst_n & periph_req & ~reqf_full;
    assign csb_nposted = 1'b1;

    always_comb begin
        new_req       = '0;
        new_req.addr  = {2'b00, periph_add[15:2]};
        new_req.data  = periph_data;
        new_req.write = ~periph_wen;
        new_req.id    = periph_id;
        new_req.err   = (CHECK_ID && (periph_add[31:16] != CSB_ID)) ||
                        (periph_add[1:0] != 2'b00) ||
                        (~periph_wen && (periph_be != 4'hF));
    end

    fifo #(.WIDTH($bits(req_t)), .DEPTH(REQ_DEPTH)) u_reqf (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (periph_gnt),
        .push_dat (new_req),
        .pop      (reqf_pop),
        .pop_dat  (reqf_head),
        .full     (reqf_full),
        .empty    (reqf_empty)
    );

    // An empty FIFO is bypassed so a fresh request reaches the CSB bus one cycle after grant.
    assign head_vld = ~reqf_empty | periph_gnt;
    assign head     = reqf_empty ? new_req : reqf_head;

    assign reqf_pop = ((state == ISSUE) & csb_ready) | ((state == ERRWAIT) & trk_empty);
    assign trk_push = reqf_pop;

    always_comb begin
        trk_push_dat       = '0;
        trk_push_dat.id    = reqf_head.id;
        trk_push_dat.write = reqf_head.write;
        trk_push_dat.err   = (state == ERRWAIT);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            csb_valid <= 1'b0;
            csb_addr  <= '0;
            csb_wdat  <= '0;
            csb_write <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (head_vld && head.err) begin
                        state <= ERRWAIT;
                    end else if (head_vld && !trk_full) begin
                        state     <= ISSUE;
                        csb_valid <= 1'b1;
                        csb_addr  <= head.addr;
                        csb_wdat  <= head.data;
                        csb_write <= head.write;
                    end
                end
                ISSUE: begin
                    if (csb_ready) begin
                        state     <= IDLE;
                        csb_valid <= 1'b0;
                    end
                end
                ERRWAIT: begin
                    if (trk_empty) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    fifo #(.WIDTH($bits(trk_t)), .DEPTH(MAX_OUTST)) u_trk (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (trk_push),
        .push_dat (trk_push_dat),
        .pop      (trk_pop),
        .pop_dat  (trk_head),
        .full     (trk_full),
        .empty    (trk_empty)
    );

    // Responses that do not match the tracker head are flagged and dropped.
    assign hd_ok    = ~trk_empty & ~trk_head.err;
    assign rd_hit   = csb_r_valid & hd_ok & ~trk_head.write;
    assign wr_hit   = csb_wr_complete & hd_ok & trk_head.write;
    assign err_done = ~trk_empty & trk_head.err;
    assign trk_pop  = rd_hit | wr_hit | err_done;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            periph_r_valid <= 1'b0;
            periph_r_data  <= '0;
            periph_r_id    <= '0;
            periph_r_err   <= 1'b0;
            unexp_resp     <= 1'b0;
        end else begin
            periph_r_valid <= trk_pop;
            if (trk_pop) begin
                periph_r_id  <= trk_head.id;
                periph_r_err <= trk_head.err;
                if (trk_head.err) begin
                    periph_r_data <= ERR_DATA;
                end else if (trk_head.write) begin
                    periph_r_data <= '0;
                end else begin
                    periph_r_data <= csb_r_data;
                end
            end
            if ((csb_r_valid && !rd_hit) || (csb_wr_complete && !wr_hit)) begin
                unexp_resp <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_periph_to_csb_pipelined.sv
// Scoreboard bench for periph_to_csb_pipelined: directed stimulus, CSB slave model, response monitor.
module tb_periph_to_csb_pipelined;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        periph_req;
    logic [31:0] periph_add;
    logic        periph_wen;
    logic [3:0]  periph_be;
    logic [31:0] periph_data;
    logic [7:0]  periph_id;
    logic        periph_gnt;
    logic        periph_r_valid;
    logic [31:0] periph_r_data;
    logic [7:0]  periph_r_id;
    logic        periph_r_err;
    logic        csb_valid;
    logic        csb_ready;
    logic [15:0] csb_addr;
    logic [31:0] csb_wdat;
    logic        csb_write;
    logic        csb_nposted;
    logic        csb_r_valid;
    logic [31:0] csb_r_data;
    logic        csb_wr_complete;
    logic        unexp_resp;

    always #5 clk = ~clk;

    periph_to_csb_pipelined dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .periph_req      (periph_req),
        .periph_add      (periph_add),
        .periph_wen      (periph_wen),
        .periph_be       (periph_be),
        .periph_data     (periph_data),
        .periph_id       (periph_id),
        .periph_gnt      (periph_gnt),
        .periph_r_valid  (periph_r_valid),
        .periph_r_data   (periph_r_data),
        .periph_r_id     (periph_r_id),
        .periph_r_err    (periph_r_err),
        .csb_valid       (csb_valid),
        .csb_ready       (csb_ready),
        .csb_addr        (csb_addr),
        .csb_wdat        (csb_wdat),
        .csb_write       (csb_write),
        .csb_nposted     (csb_nposted),
        .csb_r_valid     (csb_r_valid),
        .csb_r_data      (csb_r_data),
        .csb_wr_complete (csb_wr_complete),
        .unexp_resp      (unexp_resp)
    );

    typedef struct {
        logic [15:0] addr;
        logic [31:0] wdat;
        logic        write;
        logic [31:0] rdata;
    } csb_exp_t;

    typedef struct {
        logic [7:0]  id;
        logic [31:0] data;
        logic        err;
    } rsp_exp_t;

    typedef struct {
        int          ready_at;
        logic        write;
        logic [31:0] rdata;
    } pend_t;

    csb_exp_t csb_q[$];
    rsp_exp_t rsp_q[$];
    pend_t    pend_q[$];

    int checks = 0;
    int errors = 0;
    int pcyc = 0;
    int hs_cnt = 0;
    int resp_delay = 1;
    int gnt_cyc = 0;

    always @(posedge clk) pcyc <= pcyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic flag_fail(input string name, input logic [31:0] act);
        checks++;
        errors++;
        $display("FAIL %s actual=%h required=none", name, act);
    endtask

    // CSB slave model: checks each handshake against the expected queue, replies after resp_delay.
    initial begin
        logic        stall_prev;
        logic [15:0] held_addr;
        logic [31:0] held_wdat;
        logic        held_write;
        pend_t       p;
        csb_exp_t    e;
        stall_prev = 1'b0;
        held_addr = '0;
        held_wdat = '0;
        held_write = 1'b0;
        csb_r_valid = 1'b0;
        csb_wr_complete = 1'b0;
        csb_r_data = '0;
        forever begin
            @(negedge clk);
            #1;
            csb_r_valid = 1'b0;
            csb_wr_complete = 1'b0;
            csb_r_data = '0;
            if (pend_q.size() > 0 && pend_q[0].ready_at <= pcyc) begin
                p = pend_q.pop_front();
                if (p.write) begin
                    csb_wr_complete = 1'b1;
                end else begin
                    csb_r_valid = 1'b1;
                    csb_r_data = p.rdata;
                end
            end
            if (stall_prev && rst_n) begin
                chk("csb_hold_valid", {31'b0, csb_valid}, 32'd1);
                chk("csb_hold_addr", {16'b0, csb_addr}, {16'b0, held_addr});
                chk("csb_hold_wdat", csb_wdat, held_wdat);
                chk("csb_hold_write", {31'b0, csb_write}, {31'b0, held_write});
            end
            stall_prev = rst_n && csb_valid && !csb_ready;
            held_addr = csb_addr;
            held_wdat = csb_wdat;
            held_write = csb_write;
            if (rst_n && csb_valid && csb_ready) begin
                hs_cnt++;
                if (csb_q.size() == 0) begin
                    flag_fail("csb_unexpected_req", {16'b0, csb_addr});
                end else begin
                    e = csb_q.pop_front();
                    chk("csb_addr", {16'b0, csb_addr}, {16'b0, e.addr});
                    chk("csb_write", {31'b0, csb_write}, {31'b0, e.write});
                    if (e.write) begin
                        chk("csb_wdat", csb_wdat, e.wdat);
                    end
                    pend_q.push_back('{pcyc + resp_delay, e.write, e.rdata});
                end
            end
        end
    end

    // Response monitor.
    initial begin
        rsp_exp_t r;
        forever begin
            @(negedge clk);
            #1;
            if (rst_n && periph_r_valid) begin
                if (rsp_q.size() == 0) begin
                    flag_fail("rsp_unexpected_id", {24'b0, periph_r_id});
                end else begin
                    r = rsp_q.pop_front();
                    chk("rsp_id", {24'b0, periph_r_id}, {24'b0, r.id});
                    chk("rsp_data", periph_r_data, r.data);
                    chk("rsp_err", {31'b0, periph_r_err}, {31'b0, r.err});
                end
            end
        end
    end

    task automatic send(input logic [31:0] add, input logic wen, input logic [3:0] be,
                        input logic [31:0] data, input logic [7:0] id);
        logic g;
        g = 1'b0;
        periph_req = 1'b1;
        periph_add = add;
        periph_wen = wen;
        periph_be = be;
        periph_data = data;
        periph_id = id;
        for (int t = 0; t < 300; t++) begin
            #1;
            g = periph_gnt;
            if (g) gnt_cyc = pcyc;
            @(negedge clk);
            if (g) break;
        end
        periph_req = 1'b0;
        if (!g) flag_fail("gnt_timeout", {24'b0, id});
    endtask

    task automatic exp_rd(input logic [15:0] caddr, input logic [7:0] id, input logic [31:0] rdata);
        csb_q.push_back('{caddr, 32'h0, 1'b0, rdata});
        rsp_q.push_back('{id, rdata, 1'b0});
    endtask

    task automatic exp_wr(input logic [15:0] caddr, input logic [7:0] id, input logic [31:0] wdat);
        csb_q.push_back('{caddr, wdat, 1'b1, 32'h0});
        rsp_q.push_back('{id, 32'h0, 1'b0});
    endtask

    task automatic exp_err(input logic [7:0] id);
        rsp_q.push_back('{id, 32'hBADC0DE5, 1'b1});
    endtask

    task automatic wait_drain(input string name, input int max);
        logic done;
        done = 1'b0;
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            #2;
            if (rsp_q.size() == 0 && pend_q.size() == 0 && csb_q.size() == 0) begin
                done = 1'b1;
                break;
            end
        end
        @(negedge clk);
        if (!done) flag_fail(name, rsp_q.size());
    endtask

    task automatic wait_rvalid(output logic seen);
        seen = 1'b0;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            #1;
            if (periph_r_valid) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) flag_fail("rvalid_timeout", 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog_timeout actual=%0d required=finish", pcyc);
        $fatal(1);
    end

    initial begin
        logic seen;
        int   h0;
        rst_n = 1'b0;
        csb_ready = 1'b1;
        periph_req = 1'b1;
        periph_add = 32'h40;
        periph_wen = 1'b1;
        periph_be = 4'hF;
        periph_data = '0;
        periph_id = '0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_gnt", {31'b0, periph_gnt}, 32'd0);
        chk("rst_r_valid", {31'b0, periph_r_valid}, 32'd0);
        chk("rst_r_data", periph_r_data, 32'd0);
        chk("rst_csb_valid", {31'b0, csb_valid}, 32'd0);
        chk("rst_csb_addr", {16'b0, csb_addr}, 32'd0);
        chk("rst_unexp", {31'b0, unexp_resp}, 32'd0);
        @(negedge clk);
        periph_req = 1'b0;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single read with best-case CSB latency.
        resp_delay = 1;
        exp_rd(16'h0010, 8'h11, 32'h1234_5678);
        send(32'h0000_0040, 1'b1, 4'h0, 32'h0, 8'h11);
        wait_rvalid(seen);
        if (seen) chk("rd_latency", pcyc - gnt_cyc, 32'd3);
        wait_drain("drain_read", 50);

        // Single write.
        exp_wr(16'h0021, 8'h22, 32'hA5A5_A5A5);
        send(32'h0000_0084, 1'b0, 4'hF, 32'hA5A5_A5A5, 8'h22);
        wait_drain("drain_write", 50);

        // Six back-to-back reads, slow responses.
        resp_delay = 5;
        for (int i = 1; i <= 6; i++) exp_rd(16'h0040 + 16'(i), 8'(i), 32'hC0DE_0000 + 32'(i));
        h0 = hs_cnt;
        fork
            for (int i = 1; i <= 6; i++) send(32'h100 + 32'(4 * i), 1'b1, 4'h0, 32'h0, 8'(i));
            begin
                wait_rvalid(seen);
                chk("hs_before_first_rsp_le4", {31'b0, (hs_cnt - h0) <= 4}, 32'd1);
            end
        join
        wait_drain("drain_b2b", 200);

        // Filtered accesses interleaved with good reads.
        resp_delay = 1;
        exp_rd(16'h0008, 8'h30, 32'h0000_3030);
        exp_err(8'h31);
        exp_err(8'h32);
        exp_err(8'h33);
        exp_rd(16'h000C, 8'h34, 32'h3434_3434);
        send(32'h0000_0020, 1'b1, 4'h0, 32'h0, 8'h30);
        send(32'h0001_0000, 1'b1, 4'hF, 32'h0, 8'h31);
        send(32'h0000_0080, 1'b0, 4'h3, 32'hDEAD_BEEF, 8'h32);
        send(32'h0000_0042, 1'b1, 4'hF, 32'h0, 8'h33);
        send(32'h0000_0030, 1'b1, 4'h0, 32'h0, 8'h34);
        wait_drain("drain_err", 100);

        // CSB stalled: request FIFO fills, payload must stay put.
        resp_delay = 2;
        csb_ready = 1'b0;
        for (int i = 0; i < 5; i++) exp_wr(16'h0050 + 16'(i), 8'h41 + 8'(i), 32'h5000_0000 + 32'(i));
        for (int i = 0; i < 4; i++) send(32'h140 + 32'(4 * i), 1'b0, 4'hF, 32'h5000_0000 + 32'(i), 8'h41 + 8'(i));
        periph_req = 1'b1;
        periph_add = 32'h150;
        periph_wen = 1'b0;
        periph_be = 4'hF;
        periph_data = 32'h5000_0004;
        periph_id = 8'h45;
        #1;
        chk("gnt_full", {31'b0, periph_gnt}, 32'd0);
        repeat (6) @(negedge clk);
        #1;
        chk("gnt_full_held", {31'b0, periph_gnt}, 32'd0);
        @(negedge clk);
        fork
            send(32'h150, 1'b0, 4'hF, 32'h5000_0004, 8'h45);
            begin
                repeat (3) @(negedge clk);
                csb_ready = 1'b1;
            end
        join
        wait_drain("drain_bp", 200);
        #1;
        chk("unexp_clean", {31'b0, unexp_resp}, 32'd0);
        @(negedge clk);

        // Reset with two reads outstanding; their late responses are strays.
        resp_delay = 20;
        csb_q.push_back('{16'h0060, 32'h0, 1'b0, 32'h6060_6060});
        csb_q.push_back('{16'h0061, 32'h0, 1'b0, 32'h6161_6161});
        h0 = hs_cnt;
        send(32'h180, 1'b1, 4'h0, 32'h0, 8'h51);
        send(32'h184, 1'b1, 4'h0, 32'h0, 8'h52);
        seen = 1'b0;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            #2;
            if (hs_cnt - h0 >= 2) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) flag_fail("rst_hs_timeout", hs_cnt - h0);
        @(negedge clk);
        rst_n = 1'b0;
        periph_req = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("mid_rst_gnt", {31'b0, periph_gnt}, 32'd0);
        chk("mid_rst_r_valid", {31'b0, periph_r_valid}, 32'd0);
        chk("mid_rst_r_id", {24'b0, periph_r_id}, 32'd0);
        chk("mid_rst_csb_valid", {31'b0, csb_valid}, 32'd0);
        chk("mid_rst_unexp", {31'b0, unexp_resp}, 32'd0);
        @(negedge clk);
        periph_req = 1'b0;
        rst_n = 1'b1;
        wait_drain("drain_stray", 60);
        #1;
        chk("stray_unexp", {31'b0, unexp_resp}, 32'd1);
        chk("stray_no_rvalid", {31'b0, periph_r_valid}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
